ocl_regbus_bridge: RTL

//  AXI-Lite slave front-end for the OCL BAR0 path: sits between the OCL register slice and
//  the Ising array's register interface. Converts single-beat AXI-Lite reads/writes into
//  one-cycle register-bus strobes, and returns AXI responses. Checks address range,

---
 rtl/ocl_regbus_bridge.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/ocl_regbus_bridge.sv
// rtl/ocl_regbus_bridge.sv - AXI-Lite slave to one-cycle register-bus strobe bridge
// Range, alignment and strobe checking; every downstream read is bounded by a timeout.
module ocl_regbus_bridge #(
  parameter logic [31:0] ADDR_LIMIT   = 32'h0001_0000,
  parameter int          RD_TIMEOUT   = 255,
  parameter logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        axi_rstn,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] awaddr,
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp,
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        reg_wr_en,
  output logic [31:0] reg_wr_addr,
  output logic [31:0] reg_wdata,
  output logic        reg_rd_en,
  output logic [31:0] reg_rd_addr,
  input  logic        reg_rd_valid,
  input  logic [31:0] reg_rd_data,
  input  logic        reg_rd_err
);

  localparam int CNT_W = (RD_TIMEOUT < 2) ? 1 : $clog2(RD_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(RD_TIMEOUT);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_DATA = 3'd1,
    WR_RESP = 3'd2,
    RD_WAIT = 3'd3,
    RD_RESP = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              rvalid_q, rvalid_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              wr_en_q, wr_en_d;
  logic              rd_en_q, rd_en_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  cnt_inc;

  function automatic logic addr_bad(input logic [31:0] a);
    return (a >= ADDR_LIMIT) || (a[1:0] != 2'b00);
  endfunction

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    rvalid_d = rvalid_q;
    rresp_d  = rresp_q;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;
    wr_en_d  = 1'b0;
    rd_en_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // A write wins when both address channels are valid together.
        if (awvalid) begin
          addr_d  = awaddr;
          state_d = WR_DATA;
        end else if (arvalid) begin
          addr_d = araddr;
          if (addr_bad(araddr)) begin
            rvalid_d = 1'b1;
            rresp_d  = RESP_DECERR;
            rdata_d  = 32'h0;
            state_d  = RD_RESP;
          end else begin
            rd_en_d = 1'b1;
            state_d = RD_WAIT;
          end
        end
      end
      WR_DATA: begin
        if (wvalid) begin
          wdata_d  = wdata;
          bvalid_d = 1'b1;
          state_d  = WR_RESP;
          if (addr_bad(addr_q)) begin
            bresp_d = RESP_DECERR;
          end else if (wstrb != 4'hF) begin
            bresp_d = RESP_SLVERR;
          end else begin
            bresp_d = RESP_OKAY;
            wr_en_d = 1'b1;
          end
        end
      end
      WR_RESP: begin
        if (bready) begin
          bvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      RD_WAIT: begin
        cnt_d = cnt_inc;
        // Downstream data takes precedence over a timeout landing in the same cycle.
        if (reg_rd_valid) begin
          rdata_d  = reg_rd_data;
          rresp_d  = reg_rd_err ? RESP_SLVERR : RESP_OKAY;
          rvalid_d = 1'b1;
          cnt_d    = '0;
          state_d  = RD_RESP;
        end else if (cnt_inc == TO_CNT) begin
          rdata_d  = TIMEOUT_DATA;
          rresp_d  = RESP_SLVERR;
          rvalid_d = 1'b1;
          cnt_d    = '0;
          state_d  = RD_RESP;
        end
      end
      RD_RESP: begin
        if (rready) begin
          rvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!axi_rstn) begin
      state_q  <= IDLE;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      bvalid_q <= 1'b0;
      bresp_q  <= 2'b00;
      rvalid_q <= 1'b0;
      rresp_q  <= 2'b00;
      rdata_q  <= 32'h0;
      wr_en_q  <= 1'b0;
      rd_en_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      bvalid_q <= bvalid_d;
      bresp_q  <= bresp_d;
      rvalid_q <= rvalid_d;
      rresp_q  <= rresp_d;
      rdata_q  <= rdata_d;
      wr_en_q  <= wr_en_d;
      rd_en_q  <= rd_en_d;
      cnt_q    <= cnt_d;
    end
  end

  // arready is held low while reset is asserted so the reset state shows only awready high.
  assign awready     = (state_q == IDLE);
  assign arready     = (state_q == IDLE) && !awvalid && axi_rstn;
  assign wready      = (state_q == WR_DATA);
  assign bvalid      = bvalid_q;
  assign bresp       = bresp_q;
  assign rvalid      = rvalid_q;
  assign rresp       = rresp_q;
  assign rdata       = rdata_q;
  assign reg_wr_en   = wr_en_q;
  assign reg_wr_addr = addr_q;
  assign reg_wdata   = wdata_q;
  assign reg_rd_en   = rd_en_q;
  assign reg_rd_addr = addr_q;

endmodule
